// File: rtl/alu_pkg.sv
// Shared ALU operation codes, execute-unit states and iteration constants.
// Imported by the ALU controller and by the execute unit.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;
  localparam int MUL_ITERS      = ALU_DATA_WIDTH;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_XOR  = 4'b0010,
    OP_ADD  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_EQ   = 4'b0101,
    OP_NE   = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_MUL  = 4'b1011,
    OP_RSV0 = 4'b1100,
    OP_RSV1 = 4'b1101,
    OP_RSV2 = 4'b1110,
    OP_RSV3 = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2,
    S_DONE  = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath for one-bit-per-cycle shifts and shift-add multiply.
// done is high in the cycle whose clock edge completes the final iteration; result is valid then.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int ITERS      = MUL_ITERS,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  alu_op_e               kind,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(ITERS + 1);

  alu_op_e               kind_q;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] sreg;
  logic [DATA_WIDTH-1:0] mreg;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] acc_next;

  // For MUL, sreg holds the multiplicand and doubles every step.
  always_comb begin
    shifted = sreg << 1;
    case (kind_q)
      OP_SRL:  shifted = sreg >> 1;
      OP_SRA:  shifted = {sreg[DATA_WIDTH-1], sreg[DATA_WIDTH-1:1]};
      default: shifted = sreg << 1;
    endcase
  end

  assign acc_next = mreg[0] ? (acc + sreg) : acc;
  assign result   = (kind_q == OP_MUL) ? acc_next : shifted;
  assign done     = (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_q <= OP_AND;
      cnt    <= '0;
      sreg   <= '0;
      mreg   <= '0;
      acc    <= '0;
    end else if (flush) begin
      cnt    <= '0;
      acc    <= '0;
    end else if (start) begin
      kind_q <= kind;
      cnt    <= (kind == OP_MUL) ? CNT_W'(ITERS) : CNT_W'(b[SHAMT_W-1:0]);
      sreg   <= a;
      mreg   <= b;
      acc    <= '0;
    end else if (cnt != '0) begin
      cnt    <= cnt - CNT_W'(1);
      sreg   <= shifted;
      mreg   <= mreg >> 1;
      acc    <= acc_next;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops plus iterative shifts and multiply.
//   state   | meaning
//   S_IDLE  | ready, no result pending
//   S_SHIFT | iterative shift in flight, not ready
//   S_MUL   | shift-add multiply in flight, not ready
//   S_DONE  | result presented for one cycle, ready for the next request
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  branch_taken,
  output logic                  op_illegal
);

  alu_op_e               op;
  alu_state_e            state;
  logic                  accept;
  logic                  is_shift_op;
  logic                  start_iter;
  logic                  iter_done;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] comb_result;
  logic [DATA_WIDTH-1:0] iter_result;
  logic                  comb_branch;
  logic                  comb_illegal;

  assign op          = alu_op_e'(operation);
  assign shamt       = src_b[SHAMT_W-1:0];
  assign in_ready    = (state == S_IDLE) || (state == S_DONE);
  assign accept      = in_valid && in_ready && !flush;
  assign is_shift_op = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  // A zero-distance shift completes in one cycle like the plain ops.
  assign start_iter  = accept && ((is_shift_op && (shamt != '0)) || (op == OP_MUL));

  always_comb begin
    comb_result  = '0;
    comb_branch  = 1'b0;
    comb_illegal = 1'b0;
    case (op)
      OP_AND: comb_result = src_a & src_b;
      OP_OR:  comb_result = src_a | src_b;
      OP_XOR: comb_result = src_a ^ src_b;
      OP_ADD: comb_result = src_a + src_b;
      OP_SUB: comb_result = src_a - src_b;
      OP_EQ: begin
        comb_result = DATA_WIDTH'(src_a == src_b);
        comb_branch = comb_result[0];
      end
      OP_NE: begin
        comb_result = DATA_WIDTH'(src_a != src_b);
        comb_branch = comb_result[0];
      end
      OP_SLT: begin
        comb_result = DATA_WIDTH'($signed(src_a) < $signed(src_b));
        comb_branch = comb_result[0];
      end
      OP_SLL, OP_SRL, OP_SRA: comb_result = src_a;
      OP_MUL: comb_result = '0;
      default: comb_illegal = 1'b1;
    endcase
  end

  alu_iter_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ITERS      (DATA_WIDTH),
    .SHAMT_W    (SHAMT_W)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start_iter),
    .flush  (flush),
    .kind   (op),
    .a      (src_a),
    .b      (src_b),
    .done   (iter_done),
    .result (iter_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      out_valid    <= 1'b0;
      alu_result   <= '0;
      branch_taken <= 1'b0;
      op_illegal   <= 1'b0;
    end else if (flush) begin
      state        <= S_IDLE;
      out_valid    <= 1'b0;
      op_illegal   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          out_valid  <= 1'b0;
          op_illegal <= 1'b0;
          state      <= S_IDLE;
          if (accept) begin
            if (start_iter) begin
              state <= (op == OP_MUL) ? S_MUL : S_SHIFT;
            end else begin
              alu_result   <= comb_result;
              branch_taken <= comb_branch;
              op_illegal   <= comb_illegal;
              out_valid    <= 1'b1;
              state        <= S_DONE;
            end
          end
        end
        S_SHIFT, S_MUL: begin
          if (iter_done) begin
            alu_result   <= iter_result;
            branch_taken <= 1'b0;
            out_valid    <= 1'b1;
            state        <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic        op_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] last_res;
  logic        last_br;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .operation    (operation),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush        (flush),
    .out_valid    (out_valid),
    .alu_result   (alu_result),
    .branch_taken (branch_taken),
    .op_illegal   (op_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    logic [4:0]  s;
    s = b[4:0];
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a ^ b;
      4'd3:  r = a + b;
      4'd4:  r = a - b;
      4'd5:  r = {31'b0, a == b};
      4'd6:  r = {31'b0, a != b};
      4'd7:  r = {31'b0, $signed(a) < $signed(b)};
      4'd8:  r = a << s;
      4'd9:  r = a >> s;
      4'd10: r = $signed(a) >>> s;
      4'd11: r = a * b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'd8 || op == 4'd9 || op == 4'd10) && b[4:0] != 5'd0) return 1 + int'(b[4:0]);
    if (op == 4'd11) return 33;
    return 1;
  endfunction

  // Called at a falling edge; returns at the falling edge where out_valid is seen.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int k;
    int busy;
    logic [31:0] er;
    logic        eb;
    int          el;
    er = ref_result(op, a, b);
    eb = (op >= 4'd5 && op <= 4'd7) ? er[0] : 1'b0;
    el = ref_latency(op, b);
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk($sformatf("%s_ready_timeout", tag), 32'(in_ready), 32'd1);
    in_valid = 1'b1; operation = op; src_a = a; src_b = b;
    @(negedge clk);
    in_valid = 1'b0; operation = 4'($urandom); src_a = $urandom; src_b = $urandom;
    k = 1;
    busy = 0;
    while (!out_valid && k < 50) begin
      if (!in_ready) busy++;
      @(negedge clk);
      k++;
    end
    chk($sformatf("%s_latency", tag), 32'(k), 32'(el));
    chk($sformatf("%s_busy", tag), 32'(busy), 32'(el - 1));
    chk($sformatf("%s_result", tag), alu_result, er);
    chk($sformatf("%s_branch", tag), 32'(branch_taken), 32'(eb));
    chk($sformatf("%s_illegal", tag), 32'(op_illegal), 32'(op >= 4'd12));
    last_res = er;
    last_br  = eb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_hold", alu_result, last_res);
      chk("idle_hold_br", 32'(branch_taken), 32'(last_br));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int seen;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    operation = 4'd0; src_a = 32'd0; src_b = 32'd0;
    last_res = 32'd0; last_br = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", alu_result, 32'd0);
    chk("rst_branch", 32'(branch_taken), 32'd0);
    chk("rst_illegal", 32'(op_illegal), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Directed cases, issued back to back.
    run_op("add_ovf", 4'd3, 32'h7FFF_FFFF, 32'h1);
    run_op("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'h1);
    run_op("eq", 4'd5, 32'd5, 32'd5);
    run_op("ne", 4'd6, 32'd5, 32'd5);
    run_op("sra4", 4'd10, 32'h8000_0000, 32'd4);
    chk("sra4_value", alu_result, 32'hF800_0000);
    run_op("sll0", 4'd8, 32'h1234_5678, 32'd0);
    run_op("mul", 4'd11, 32'hFFFF_FFFF, 32'd3);
    chk("mul_value", alu_result, 32'hFFFF_FFFD);
    run_op("rsv", 4'd13, 32'hDEAD_BEEF, 32'h1);
    idle(2);

    // Second request held through a multiply must wait for in_ready.
    in_valid = 1'b1; operation = 4'd11; src_a = 32'hFFFF_FFFF; src_b = 32'd3;
    @(negedge clk);
    operation = 4'd3; src_a = 32'd2; src_b = 32'd3;
    k = 1;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("hold_mul_latency", 32'(k), 32'd33);
    chk("hold_mul_result", alu_result, 32'hFFFF_FFFD);
    @(negedge clk);
    in_valid = 1'b0;
    chk("hold_add_valid", 32'(out_valid), 32'd1);
    chk("hold_add_result", alu_result, 32'd5);
    last_res = 32'd5; last_br = 1'b0;
    idle(1);

    // Flush a multiply at t+10.
    in_valid = 1'b1; operation = 4'd11; src_a = 32'd7; src_b = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_result", 32'(seen), 32'd0);
    chk("flush_hold", alu_result, last_res);
    run_op("post_flush_add", 4'd3, 32'd100, 32'd23);

    // Flush together with a request: not accepted.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; operation = 4'd3; src_a = 32'd1; src_b = 32'd1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_req_valid", 32'(out_valid), 32'd0);
    chk("flush_req_ready", 32'(in_ready), 32'd1);
    idle(3);

    // Reset in the middle of a long shift.
    run_op("pre_rst_slt", 4'd7, 32'h8000_0000, 32'd3);
    in_valid = 1'b1; operation = 4'd10; src_a = 32'h8000_0000; src_b = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_shift_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_result", alu_result, 32'd0);
    chk("async_rst_branch", 32'(branch_taken), 32'd0);
    chk("async_rst_illegal", 32'(op_illegal), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    last_res = 32'd0; last_br = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_result", 32'(seen), 32'd0);

    // Random operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      if ($urandom_range(0, 5) == 0) rb[4:0] = 5'd0;
      run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
